// File: rtl/sys_array_pe.sv
// sys_array_pe: double-buffered-weight systolic PE with weight-stationary / output-stationary modes and chained drain.
// Define SYS_ARRAY_PE_SAT_EN to make every accumulator-width addition saturate instead of wrapping.
module sys_array_pe #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH+4,
    parameter int DRAIN_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mode,
    input  logic                  param_load,
    input  logic                  param_swap,
    input  logic [DATA_WIDTH-1:0] param_data,
    output logic [DATA_WIDTH-1:0] prop_param,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic [DATA_WIDTH-1:0] prop_input,
    output logic                  prop_valid,
    input  logic                  prop_data_valid,
    input  logic [ACC_WIDTH-1:0]  prop_data,
    input  logic                  acc_drain,
    output logic                  out_valid,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_DRAIN_HEAD = 2'd1,
        ST_DRAIN_FWD  = 2'd2
    } state_t;

    localparam logic [7:0] DEPTH_INIT = 8'(DRAIN_DEPTH);

    state_t                        r_state;
    state_t                        w_stateNext;
    logic [DATA_WIDTH-1:0]         r_shadowW;
    logic [DATA_WIDTH-1:0]         r_activeW;
    logic [ACC_WIDTH-1:0]          r_acc;
    logic [7:0]                    r_cnt;
    logic signed [2*DATA_WIDTH-1:0] w_prodFull;
    logic signed [ACC_WIDTH-1:0]   w_prod;
    logic [ACC_WIDTH-1:0]          w_wsSum;
    logic [ACC_WIDTH-1:0]          w_accSum;
    logic [ACC_WIDTH-1:0]          w_accNext;

    // Signed overflow means both operands share a sign the sum does not.
    function automatic logic [ACC_WIDTH-1:0] addAcc(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [ACC_WIDTH-1:0] b);
        logic [ACC_WIDTH-1:0] sum;
        sum = a + b;
`ifdef SYS_ARRAY_PE_SAT_EN
        if ((a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != a[ACC_WIDTH-1])) begin
            sum = a[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                 : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
`endif
        return sum;
    endfunction

    assign w_prodFull = $signed(input_data) * $signed(r_activeW);
    assign w_prod     = ACC_WIDTH'(w_prodFull);
    assign w_wsSum    = addAcc(prop_data, w_prod);
    assign w_accSum   = addAcc(r_acc, w_prod);
    assign w_accNext  = in_valid ? w_accSum : r_acc;

    assign prop_param = r_shadowW;
    assign busy       = (r_state != ST_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Mode and acc_drain only matter in RUN; a drain always runs to completion.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_RUN: begin
                if (mode && acc_drain) w_stateNext = ST_DRAIN_HEAD;
            end
            ST_DRAIN_HEAD: begin
                w_stateNext = (DRAIN_DEPTH == 0) ? ST_RUN : ST_DRAIN_FWD;
            end
            ST_DRAIN_FWD: begin
                if (r_cnt == 8'd1) w_stateNext = ST_RUN;
            end
            default: w_stateNext = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadowW  <= '0;
            r_activeW  <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            prop_input <= '0;
            prop_valid <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
        end else begin
            prop_input <= input_data;
            prop_valid <= in_valid;
            if (param_load) r_shadowW <= param_data;
            if (param_swap) r_activeW <= r_shadowW;
            case (r_state)
                ST_RUN: begin
                    if (!mode) begin
                        out_valid <= in_valid;
                        if (in_valid) out_data <= w_wsSum;
                    end else begin
                        out_valid <= 1'b0;
                        r_acc     <= w_accNext;
                    end
                end
                ST_DRAIN_HEAD: begin
                    out_data  <= w_accNext;
                    out_valid <= 1'b1;
                    r_acc     <= '0;
                    r_cnt     <= DEPTH_INIT;
                end
                ST_DRAIN_FWD: begin
                    out_data  <= prop_data;
                    out_valid <= prop_data_valid;
                    r_acc     <= w_accNext;
                    r_cnt     <= r_cnt - 8'd1;
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_array_pe.sv
// tb_sys_array_pe: directed and randomized checks of sys_array_pe against an integer reference model.
// Define SYS_ARRAY_PE_SAT_EN here as well when building the saturating variant.
module tb_sys_array_pe;

    localparam int DW    = 8;
    localparam int AW    = 20;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          modeS = 1'b0;
    logic          paramLoad = 1'b0;
    logic          paramSwap = 1'b0;
    logic [DW-1:0] paramData = '0;
    logic [DW-1:0] propParam;
    logic          inValid = 1'b0;
    logic [DW-1:0] inputData = '0;
    logic [DW-1:0] propInput;
    logic          propValid;
    logic          propDataValid = 1'b0;
    logic [AW-1:0] propData = '0;
    logic          accDrain = 1'b0;
    logic          outValid;
    logic [AW-1:0] outData;
    logic          busy;

    int numChecks = 0;
    int numFails  = 0;

    longint mShadow = 0, mActive = 0, mAcc = 0, mOut = 0, mPropInput = 0;
    longint mOutValid = 0, mPropValid = 0;
    int     mDrainLeft = 0;

    sys_array_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .DRAIN_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(resetN), .mode(modeS),
        .param_load(paramLoad), .param_swap(paramSwap), .param_data(paramData),
        .prop_param(propParam), .in_valid(inValid), .input_data(inputData),
        .prop_input(propInput), .prop_valid(propValid),
        .prop_data_valid(propDataValid), .prop_data(propData),
        .acc_drain(accDrain), .out_valid(outValid), .out_data(outData), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic longint addModel(input longint a, input longint b);
        longint span = longint'(1) << AW;
        longint s = a + b;
`ifdef SYS_ARRAY_PE_SAT_EN
        if (s > span/2 - 1) s = span/2 - 1;
        if (s < -(span/2)) s = -(span/2);
`else
        s = s % span;
        if (s < 0) s += span;
        if (s >= span/2) s -= span;
`endif
        return s;
    endfunction

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        numChecks++;
        if (got != exp) begin
            numFails++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference behaviour evaluated on the inputs present at the clock edge.
    task automatic modelStep();
        longint prod = longint'($signed(inputData)) * mActive;
        longint oldShadow = mShadow;
        mPropInput = longint'($signed(inputData));
        mPropValid = inValid;
        if (mDrainLeft == 0) begin
            if (!modeS) begin
                mOutValid = inValid;
                if (inValid) mOut = addModel(longint'($signed(propData)), prod);
            end else begin
                if (inValid) mAcc = addModel(mAcc, prod);
                mOutValid = 0;
                if (accDrain) mDrainLeft = DEPTH + 1;
            end
        end else if (mDrainLeft == DEPTH + 1) begin
            mOut = inValid ? addModel(mAcc, prod) : mAcc;
            mOutValid = 1;
            mAcc = 0;
            mDrainLeft--;
        end else begin
            mOut = longint'($signed(propData));
            mOutValid = propDataValid;
            if (inValid) mAcc = addModel(mAcc, prod);
            mDrainLeft--;
        end
        if (paramSwap) mActive = oldShadow;
        if (paramLoad) mShadow = longint'($signed(paramData));
    endtask

    task automatic compareAll();
        checkOutput("out_valid", longint'(outValid), mOutValid);
        checkOutput("out_data", longint'($signed(outData)), mOut);
        checkOutput("prop_input", longint'($signed(propInput)), mPropInput);
        checkOutput("prop_valid", longint'(propValid), mPropValid);
        checkOutput("prop_param", longint'($signed(propParam)), mShadow);
        checkOutput("busy", longint'(busy), longint'(mDrainLeft > 0));
    endtask

    task automatic applyStimulus(input bit m, input bit ld, input bit sw, input int pd,
                                 input bit iv, input int ind, input bit pdv, input int prd,
                                 input bit drn);
        modeS = m; paramLoad = ld; paramSwap = sw; paramData = DW'(pd);
        inValid = iv; inputData = DW'(ind); propDataValid = pdv; propData = AW'(prd);
        accDrain = drn;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    task automatic modelReset();
        mShadow = 0; mActive = 0; mAcc = 0; mOut = 0; mPropInput = 0;
        mOutValid = 0; mPropValid = 0; mDrainLeft = 0;
    endtask

    int busyCount;
    longint satExp;

    initial begin
        #12;
        checkOutput("rst_out_data", longint'($signed(outData)), 0);
        checkOutput("rst_out_valid", longint'(outValid), 0);
        checkOutput("rst_busy", longint'(busy), 0);
        checkOutput("rst_prop_param", longint'($signed(propParam)), 0);
        @(negedge clk);
        resetN = 1'b1;

        $display("[TB] WS basic");
        applyStimulus(0, 1, 0, 3, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, -5, 0, 100, 0);
        checkOutput("t1_out", longint'($signed(outData)), 85);
        checkOutput("t1_prop_input", longint'($signed(propInput)), -5);

        $display("[TB] double buffer");
        applyStimulus(0, 1, 0, 7, 1, 2, 0, 0, 0);
        checkOutput("t2_out_old_w", longint'($signed(outData)), 6);
        checkOutput("t2_shadow", longint'($signed(propParam)), 7);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 2, 0, 0, 0);
        checkOutput("t2_out_new_w", longint'($signed(outData)), 14);
        applyStimulus(0, 1, 1, 9, 0, 0, 0, 0, 0);
        checkOutput("t2_shadow_9", longint'($signed(propParam)), 9);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 0);
        checkOutput("t2_active_7", longint'($signed(outData)), 7);

        $display("[TB] OS accumulate and drain");
        applyStimulus(0, 1, 0, -2, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 10, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 20, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 30, 0, 0, 0);
        checkOutput("t3_os_no_valid", longint'(outValid), 0);
        busyCount = 0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        busyCount += int'(busy);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 5, 0);
        busyCount += int'(busy);
        checkOutput("t3_drain_acc", longint'($signed(outData)), -120);
        checkOutput("t3_drain_valid", longint'(outValid), 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 11, 0);
        busyCount += int'(busy);
        checkOutput("t3_fwd_11", longint'($signed(outData)), 11);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 22, 0);
        busyCount += int'(busy);
        checkOutput("t3_fwd_22", longint'($signed(outData)), 22);
        checkOutput("t3_busy_cycles", busyCount, 3);
        applyStimulus(1, 0, 0, 0, 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_fresh_acc", longint'($signed(outData)), -2);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] overflow");
        applyStimulus(0, 1, 0, 127, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 33; i++) applyStimulus(1, 0, 0, 0, 1, 127, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef SYS_ARRAY_PE_SAT_EN
        satExp = 524287;
`else
        satExp = -516319;
`endif
        checkOutput("t4_overflow", longint'($signed(outData)), satExp);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_fwd_invalid", longint'(outValid), 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] reset during drain");
        applyStimulus(1, 0, 0, 0, 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 77, 0);
        resetN = 1'b0;
        #1;
        modelReset();
        checkOutput("t5_out_data", longint'($signed(outData)), 0);
        checkOutput("t5_out_valid", longint'(outValid), 0);
        checkOutput("t5_busy", longint'(busy), 0);
        checkOutput("t5_shadow", longint'($signed(propParam)), 0);
        @(negedge clk);
        resetN = 1'b1;
        applyStimulus(0, 0, 0, 0, 1, 5, 0, 1234, 0);
        checkOutput("t5_zero_weight", longint'($signed(outData)), 1234);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("t5_no_valid", longint'(outValid), 0);

        $display("[TB] ignored controls");
        applyStimulus(0, 1, 0, 3, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 4, 0, 10, 1);
        checkOutput("t6_ws_drain_busy", longint'(busy), 0);
        checkOutput("t6_ws_out", longint'($signed(outData)), 22);
        applyStimulus(1, 0, 0, 0, 1, 2, 0, 0, 0);
        busyCount = 0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        busyCount += int'(busy);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        busyCount += int'(busy);
        checkOutput("t6_head", longint'($signed(outData)), 6);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 33, 1);
        busyCount += int'(busy);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 44, 1);
        busyCount += int'(busy);
        checkOutput("t6_fwd_44", longint'($signed(outData)), 44);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        busyCount += int'(busy);
        checkOutput("t6_busy_cycles", busyCount, 3);

        $display("[TB] random");
        for (int i = 0; i < 600; i++) begin
            bit rm;
            rm = modeS;
            if ($urandom_range(0, 19) == 0) rm = ~modeS;
            applyStimulus(rm, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                          int'($urandom), ($urandom_range(0, 3) != 0), int'($urandom),
                          ($urandom_range(0, 1) == 1), int'($urandom),
                          ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/sys_array_pe.md
Name: sys_array_pe

Overview:
Second-generation systolic processing element. Generalises the single weight-stationary multiply-accumulate cell with three additions: a double-buffered weight register, valid-qualified data flow, and a selectable output-stationary mode with an in-place accumulator and a chained result drain. One instance sits at each grid point of the parametrised systolic array. Neighbours connect through the prop_* ports.

Parameters:
DATA_WIDTH, 8, signed width of input_data, param_data, prop_input and prop_param.
ACC_WIDTH, 2*DATA_WIDTH+4, signed width of prop_data, out_data and the accumulator; must be >= 2*DATA_WIDTH.
DRAIN_DEPTH, 4, number of upstream results forwarded after this PE's own result during a drain (0..255).

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
mode  in  1  0 = weight-stationary (WS), 1 = output-stationary (OS).
param_load  in  1  capture param_data into the shadow weight.
param_swap  in  1  copy the shadow weight into the active weight.
param_data  in  DATA_WIDTH  weight in, from the upstream PE.
prop_param  out  DATA_WIDTH  shadow weight, registered; feeds the downstream weight chain.
in_valid  in  1  input_data qualifier.
input_data  in  DATA_WIDTH  activation in.
prop_input  out  DATA_WIDTH  input_data delayed 1 cycle.
prop_valid  out  1  in_valid delayed 1 cycle.
prop_data_valid  in  1  prop_data qualifier.
prop_data  in  ACC_WIDTH  partial sum (WS) or drained result (OS) from upstream.
acc_drain  in  1  OS-mode request to start a drain.
out_valid  out  1  out_data qualifier.
out_data  out  ACC_WIDTH  result.
busy  out  1  high while in DRAIN.

Behaviour:
- Reset: all outputs, shadow_w, active_w, acc and drain counter = 0; state = RUN. Reset asserted mid-DRAIN aborts the drain with no further out_valid.
- Weights:
  - param_load: shadow_w <= param_data.
  - param_swap: active_w <= shadow_w (pre-edge value).
  - Both in the same cycle: active_w takes the old shadow_w and shadow_w takes param_data.
  - prop_param always equals shadow_w.
- Product: prod = sign-extended (input_data * active_w) to ACC_WIDTH.
- prop_input <= input_data and prop_valid <= in_valid every cycle, in every state and mode.
- WS mode, state RUN, 1-cycle latency:
  - in_valid = 1: out_data <= prop_data + prod and out_valid <= 1.
  - in_valid = 0: out_valid <= 0 and out_data holds.
  - prop_data_valid is ignored; acc_drain is ignored.
- OS mode, state RUN:
  - in_valid = 1: acc <= acc + prod.
  - out_valid = 0.
  - acc_drain = 1: go to DRAIN.
- DRAIN state, OS only:
  - First cycle: out_data <= acc (including any prod accepted in that cycle), out_valid <= 1, acc <= 0, counter <= DRAIN_DEPTH.
  - Each following cycle: out_data <= prop_data, out_valid <= prop_data_valid, counter decrements.
  - Return to RUN when the counter reaches 0; with DRAIN_DEPTH = 0, DRAIN lasts 1 cycle.
  - in_valid during forwarding cycles accumulates into the fresh acc.
  - acc_drain and mode changes during DRAIN are ignored.
  - busy = 1 for exactly DRAIN_DEPTH+1 cycles.
- Mode is sampled only in RUN. Switching mode does not clear acc.
- Arithmetic: two's complement, result modulo 2^ACC_WIDTH (wrap) unless the optional feature is enabled.

Optional Feature:
SYS_ARRAY_PE_SAT_EN
- Defined: every ACC_WIDTH addition (WS sum, OS accumulate) saturates to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) on signed overflow.
- Undefined: plain wrap-around, with no extra logic.

Test Plan:
1. WS, DW=8, ACC=20: load 3, swap, then in_valid=1, input=-5, prop_data=100 -> next cycle out_data=85, out_valid=1, prop_input=-5, prop_valid=1.
2. Double buffer: active=3, load 7 with no swap, input=2, prop=0 -> out_data=6, prop_param=7. Then swap, input=2 -> 14. Load 9 with swap in the same cycle -> active=7, shadow=9.
3. OS: weight -2, inputs 10, 20, 30 valid, then acc_drain -> out_data=-120 for 1 cycle; then prop_data 11 and 22 (valid) are forwarded with DRAIN_DEPTH=2; busy high 3 cycles; next accumulate starts from 0.
4. Overflow: OS, weight 127, input 127 for 33 cycles (sum 532257), then drain -> -516319 without macro, 524287 with SYS_ARRAY_PE_SAT_EN.
5. Reset mid-DRAIN: reset_n=0 on the second DRAIN cycle -> out_data=0, out_valid=0, busy=0, weights=0, state RUN. After release, a WS op with zero weights gives out_data=prop_data.
6. Ignored controls: acc_drain in WS mode, and mode toggled during DRAIN -> no state change; drain completes its full DRAIN_DEPTH+1 cycles.
